// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and the memory arbiter grant state.
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;

   localparam int ARB_STARVE_LIMIT = 4;
   localparam int ARB_TIMEOUT      = 255;
endpackage

// File: rtl/memory_arbiter_timeout_counter.sv
// Grant watchdog: counts grant cycles without ACCESS, saturating at TIMEOUT.
module arb_timeout_counter #(
   parameter int TIMEOUT = 255,
   parameter int W       = $clog2(TIMEOUT + 1)
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clear,
   input  logic en,
   output logic expired
);
   logic [W-1:0] cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (en && cnt != W'(TIMEOUT))
         cnt <= cnt + 1'b1;
   end

   // Fires on the idle cycle that would make the count reach TIMEOUT.
   assign expired = en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data load/store,
// with fetch anti-starvation and a per-grant timeout.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
   parameter int TIMEOUT      = ARB_TIMEOUT
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      bus_err
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t    state, state_n;
   logic [SW-1:0] starve_cnt;
   logic          dreq, grant, access, owner_req;
   logic          icomplete, dcomplete, abort, tmo_expired;

   assign dreq      = dREN | dWEN;
   assign grant     = (state != IDLE);
   assign access    = (ramstate == ACCESS);
   assign owner_req = (state == IGRANT) ? iREN : (state == DGRANT) ? dreq : 1'b0;
   assign icomplete = (state == IGRANT) && iREN && access;
   assign dcomplete = (state == DGRANT) && dreq && access;
   assign abort     = owner_req && !access && ((ramstate == ERROR) || tmo_expired);

   arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .CLK     (CLK),
      .nRST    (nRST),
      .clear   (!grant),
      .en      (grant && !access),
      .expired (tmo_expired)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (dreq && !(iREN && starve_cnt == SW'(STARVE_LIMIT)))
               state_n = DGRANT;
            else if (iREN)
               state_n = IGRANT;
         end
         IGRANT, DGRANT: begin
            // Completion, withdrawal and abort all leave a one-cycle bubble.
            if (!owner_req || access || abort)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      unique case (state)
         IGRANT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
         end
         DGRANT: begin
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end
         default: ;
      endcase
   end

   assign iwait = iREN & ~icomplete;
   assign dwait = dreq & ~dcomplete;
   assign iload = ramload;
   assign dload = ramload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         starve_cnt <= '0;
      else if (!iREN || icomplete)
         starve_cnt <= '0;
      else if (dcomplete && starve_cnt != SW'(STARVE_LIMIT))
         starve_cnt <= starve_cnt + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) bus_err <= 1'b0;
      else       bus_err <= abort;
   end

   // A data request may be withdrawn mid-grant but must not switch between read and write.
   a_no_dir_flip: assert property (@(posedge CLK) disable iff (!nRST)
      (state == DGRANT && $past(state == DGRANT) && dreq && $past(dREN | dWEN))
      |-> $stable(dWEN));
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   localparam int LIM = 4;
   localparam int TMO = 255;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   ramstate_t ramstate;
   logic      iwait, dwait, ramREN, ramWEN, bus_err;
   word_t     iload, dload, ramaddr, ramstore;

   memory_arbiter dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic  iwait, dwait, ramREN, ramWEN, bus_err;
      word_t ramaddr, ramstore, iload, dload;
   } obs_t;

   int errors = 0, checks = 0;

   // Model: who owns the RAM (0 none, 1 fetch, 2 data), idle age of the grant, starvation tally.
   int         own, starve, age, dcomp;
   bit         berr, idone, ddone;
   obs_t       last_o;
   arb_state_t last_st, prev_st;
   int         last_starve;
   arb_state_t grants[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      own = 0; starve = 0; age = 0; berr = 0; prev_st = IDLE;
   endtask

   task automatic step();
      obs_t e, o;
      bit   acc, dreq, req;
      @(negedge CLK);
      dreq = dREN | dWEN;
      acc  = (ramstate == ACCESS);
      e = '0;
      if (own == 1) begin
         e.ramREN = iREN; e.ramaddr = iaddr;
      end else if (own == 2) begin
         e.ramREN = dREN & ~dWEN; e.ramWEN = dWEN; e.ramaddr = daddr; e.ramstore = dstore;
      end
      e.iwait   = iREN && !(own == 1 && acc);
      e.dwait   = dreq && !(own == 2 && acc);
      e.bus_err = berr;
      e.iload   = ramload;
      e.dload   = ramload;
      o = {iwait, dwait, ramREN, ramWEN, bus_err, ramaddr, ramstore, iload, dload};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL cycle@%0t: observed %h expected %h", $time, o, e);
      end
      last_o = o;
      last_st = dut.state;
      last_starve = int'(dut.starve_cnt);
      if (last_st != IDLE && prev_st == IDLE) grants.push_back(last_st);
      prev_st = last_st;
      idone = iREN && !e.iwait;
      ddone = dreq && !e.dwait;
      if (ddone) dcomp++;
      berr = 0;
      if (own == 0) begin
         age = 0;
         if (dreq && !(iREN && starve == LIM)) own = 2;
         else if (iREN) own = 1;
      end else begin
         req = (own == 1) ? iREN : dreq;
         if (!req) own = 0;
         else if (acc) begin
            if (own == 2 && iREN && starve < LIM) starve++;
            if (own == 1) starve = 0;
            own = 0;
         end else if (ramstate == ERROR || age + 1 == TMO) begin
            own = 0; berr = 1;
         end else age++;
      end
      if (!iREN) starve = 0;
      @(posedge CLK); #1;
   endtask

   function automatic ramstate_t rand_rs();
      int r = $urandom_range(19);
      if (r < 10) return BUSY;
      if (r < 16) return ACCESS;
      if (r < 19) return FREE;
      return ERROR;
   endfunction

   initial begin
      bit iw_ok, sc_done;
      int r;
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = 32'hdead_beef; ramstate = FREE;
      model_reset();
      #1;
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_ramstore", ramstore, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_state", dut.state, IDLE);
      chk("rst_starve", dut.starve_cnt, 0);
      chk("rst_tmo", dut.u_tmo.cnt, 0);
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;

      // Fetch only, two BUSY cycles then ACCESS.
      iREN = 1; iaddr = 32'h100; ramstate = BUSY;
      step(); step(); step();
      ramstate = ACCESS; ramload = 32'h1234_5678;
      step();
      chk("fetch_ramREN", last_o.ramREN, 1);
      chk("fetch_ramaddr", last_o.ramaddr, 32'h100);
      chk("fetch_iwait", last_o.iwait, 0);
      chk("fetch_iload", last_o.iload, 32'h1234_5678);
      iREN = 0; ramstate = FREE;
      step();
      chk("fetch_idle", last_st, IDLE);

      // Contention: data first, fetch waits through it.
      grants.delete(); iw_ok = 1;
      iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300; ramstate = BUSY;
      for (int c = 0; c < 20 && (iREN || dREN); c++) begin
         step();
         if (last_st == DGRANT) iw_ok &= last_o.iwait;
         if (ddone) dREN = 0;
         if (idone) iREN = 0;
         ramstate = (c % 2) ? ACCESS : BUSY;
      end
      chk("cont_ngrants", grants.size(), 2);
      chk("cont_first", grants[0], DGRANT);
      chk("cont_second", grants[1], IGRANT);
      chk("cont_iwait", iw_ok, 1);
      iREN = 0; dREN = 0; ramstate = FREE; step();

      // Starvation: stores back to back with a fetch pending.
      grants.delete(); dcomp = 0; sc_done = 0;
      iREN = 1; iaddr = 32'h400; dWEN = 1; daddr = 32'h800; dstore = 32'h1; ramstate = ACCESS;
      for (int c = 0; c < 60 && dcomp < 6; c++) begin
         step();
         if (ddone) begin
            daddr = daddr + 4; dstore = dstore + 1;
            if (dcomp == 6) dWEN = 0;
         end
         if (idone && !sc_done) begin
            chk("starve_at_limit", last_starve, LIM);
            iaddr = iaddr + 4;
            step();
            chk("starve_cleared", last_starve, 0);
            sc_done = 1;
         end
      end
      chk("starve_g0", grants[0], DGRANT);
      chk("starve_g3", grants[3], DGRANT);
      chk("starve_g4", grants[4], IGRANT);
      chk("starve_stores", dcomp, 6);
      iREN = 0; dWEN = 0; ramstate = FREE; step(); step();

      // Timeout: data grant with RAM stuck BUSY.
      dWEN = 1; daddr = 32'h900; dstore = 32'hcafe; ramstate = BUSY;
      repeat (256) step();
      chk("tmo_no_err_yet", last_o.bus_err, 0);
      step();
      chk("tmo_bus_err", last_o.bus_err, 1);
      chk("tmo_state", last_st, IDLE);
      chk("tmo_dwait", last_o.dwait, 1);
      step();
      chk("tmo_retry", last_st, DGRANT);
      chk("tmo_err_pulse", last_o.bus_err, 0);
      ramstate = ACCESS; step();
      chk("tmo_retry_done", last_o.dwait, 0);
      dWEN = 0; ramstate = FREE; step();

      // Flush in the first fetch grant cycle with a data read pending.
      iREN = 1; iaddr = 32'h500; ramstate = BUSY;
      step();
      iREN = 0; dREN = 1; daddr = 32'hA00;
      step();
      chk("flush_ramREN", last_o.ramREN, 0);
      chk("flush_in_igrant", last_st, IGRANT);
      step();
      chk("flush_idle", last_st, IDLE);
      chk("flush_no_err", last_o.bus_err, 0);
      step();
      chk("flush_dgrant", last_st, DGRANT);
      ramstate = ACCESS; step();
      dREN = 0; ramstate = FREE; step();

      // Asynchronous reset in the middle of a store.
      dWEN = 1; daddr = 32'hB00; dstore = 32'h77; ramstate = BUSY;
      step(); step();
      chk("arst_pre_wen", ramWEN, 1);
      #2 nRST = 1'b0;
      #1;
      chk("arst_ramWEN", ramWEN, 0);
      chk("arst_state", dut.state, IDLE);
      chk("arst_starve", dut.starve_cnt, 0);
      chk("arst_tmo", dut.u_tmo.cnt, 0);
      model_reset();
      dWEN = 0; ramstate = FREE;
      @(posedge CLK); #1 nRST = 1'b1;

      // Random traffic with well-behaved requesters.
      for (int c = 0; c < 3000; c++) begin
         step();
         ramstate = rand_rs();
         ramload  = $urandom;
         if (iREN) begin
            if (idone) begin
               iREN = $urandom_range(1); iaddr = $urandom;
            end else if ($urandom_range(39) == 0) iREN = 0;
         end else if ($urandom_range(2) == 0) begin
            iREN = 1; iaddr = $urandom;
         end
         if (dREN | dWEN) begin
            if (ddone) begin
               r = $urandom_range(3);
               dREN = r[0]; dWEN = r[1]; daddr = $urandom; dstore = $urandom;
            end else if ($urandom_range(49) == 0) begin
               dREN = 0; dWEN = 0;
            end
         end else if ($urandom_range(2) == 0) begin
            r = $urandom_range(1, 3);
            dREN = r[0]; dWEN = r[1]; daddr = $urandom; dstore = $urandom;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
